// File: rtl/rr_arb2_pkg.sv
// Shared constants and types for the rr_arb2 two-input round-robin arbiter.
package rr_arb2_pkg;

    localparam logic SRC_IN0 = 1'b0;
    localparam logic SRC_IN1 = 1'b1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // in0 wins the first contention after reset.
    localparam logic LAST_GRANT_RST = SRC_IN1;

endpackage

// File: rtl/rr_arb2_grant.sv
// Combinational round-robin grant for rr_arb2; lock overrides, idle holds idle_sel.
module rr_arb2_grant
    import rr_arb2_pkg::*;
(
    input  logic in0_valid,
    input  logic in1_valid,
    input  logic last_grant,
    input  logic idle_sel,
    input  logic lock,
    input  logic lock_src,
    output logic sel
);

    always_comb begin
        // NOTE: default assignment first so no path leaves sel unassigned (no latch).
        sel = idle_sel;
        if (lock) begin
            sel = lock_src;
        end else if (in0_valid && in1_valid) begin
            sel = ~last_grant;
        end else if (in0_valid) begin
            sel = SRC_IN0;
        end else if (in1_valid) begin
            sel = SRC_IN1;
        end
    end

endmodule

// File: rtl/rr_arb2_mux2.sv
// Single-bit 2:1 mux cell; s=0 selects a, s=1 selects b.
module rr_arb2_mux2 (
    input  logic a,
    input  logic b,
    input  logic s,
    output logic y
);

    assign y = s ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin stream arbiter with one registered output stage.
// Define RR_ARB2_LOCK_EN to hold the grant for a whole packet (until inN_last).
module rr_arb2
    import rr_arb2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             sel
);

    state_t           state;
    logic             last_grant;
    logic             lock;
    logic             lock_src;
    logic             can_load;
    logic             xfer;
    logic             xfer_last;
    logic [WIDTH-1:0] mux_data;

    assign out_valid = (state == FULL);
    assign can_load  = ~out_valid | out_ready;
    assign in0_ready = can_load & (sel == SRC_IN0);
    assign in1_ready = can_load & (sel == SRC_IN1);
    assign xfer      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
    assign xfer_last = sel ? in1_last : in0_last;

    // With no valid input the select stays on the source of the last accepted beat.
    rr_arb2_grant u_grant (
        .in0_valid  (in0_valid),
        .in1_valid  (in1_valid),
        .last_grant (last_grant),
        .idle_sel   (out_src),
        .lock       (lock),
        .lock_src   (lock_src),
        .sel        (sel)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        rr_arb2_mux2 u_mux (
            .a (in0_data[i]),
            .b (in1_data[i]),
            .s (sel),
            .y (mux_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments for all registered state.
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= SRC_IN0;
            last_grant <= LAST_GRANT_RST;
        end else if (xfer) begin
            state    <= FULL;
            out_data <= mux_data;
            out_src  <= sel;
`ifdef RR_ARB2_LOCK_EN
            if (xfer_last) begin
                last_grant <= sel;
            end
`else
            last_grant <= sel;
`endif
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

`ifdef RR_ARB2_LOCK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_src <= SRC_IN0;
        end else if (xfer) begin
            lock     <= ~xfer_last;
            lock_src <= sel;
        end
    end
`else
    logic unused_last;
    assign unused_last = xfer_last;
    assign lock        = 1'b0;
    assign lock_src    = SRC_IN0;
`endif

endmodule

// File: tb/tb_rr_arb2.sv
// Scoreboard bench for rr_arb2: stimulus pushes hand-computed beats, a monitor pops on output handshakes.
module tb_rr_arb2;
    import rr_arb2_pkg::*;

    typedef struct packed {
        logic [7:0] data;
        logic       src;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in0_valid = 1'b0, in1_valid = 1'b0;
    logic [7:0] in0_data = '0, in1_data = '0;
    logic       in0_last = 1'b0, in1_last = 1'b0;
    logic       in0_ready, in1_ready;
    logic       out_valid, out_src, out_ready = 1'b0, sel;
    logic [7:0] out_data;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    rr_arb2 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .sel       (sel)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output handshake consumes one expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {out_src, out_data}, 32'hFFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_src", out_src, e.src);
            end
        end
    end

    task automatic idle_inputs();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_last  = 1'b0;
        in1_last  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        exp_q.push_back('{data: d, src: s});
    endtask

    // Ends at posedge+1 with inputs idle and the expected queue drained.
    task automatic drain();
        idle_inputs();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        drain();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    // One cycle: inputs already applied at posedge+1, ready checks at negedge.
    task automatic cycle_end();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        check("rst_sel", sel, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single source in0
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA5;
        @(negedge clk);
        check("t1_in0_ready", in0_ready, 1);
        check("t1_in1_ready", in1_ready, 0);
        push(8'hA5, SRC_IN0);
        cycle_end();
        in0_valid = 1'b0;
        check("t1_out_valid", out_valid, 1);

        // Both valid: strict alternation starting with in0
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2_sel", sel, i % 2);
            push(i % 2 ? 8'h22 : 8'h11, (i % 2) != 0);
            cycle_end();
        end

        // Stall while FULL, then drain+load with no bubble
        do_reset();
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        push(8'h11, SRC_IN0);
        cycle_end();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_in0_ready", in0_ready, 0);
            check("t3_in1_ready", in1_ready, 0);
            check("t3_out_data", out_data, 8'h11);
            cycle_end();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_in1_ready_nobubble", in1_ready, 1);
        push(8'h22, SRC_IN1);
        cycle_end();
        in1_valid = 1'b0;
        in0_valid = 1'b0;
        @(negedge clk);
        check("t3_out_valid", out_valid, 1);
        cycle_end();

        // in1 alone for 4 beats, then first contention goes to in0
        do_reset();
        in1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in1_data = 8'h30 + 8'(i);
            @(negedge clk);
            check("t4_in1_ready", in1_ready, 1);
            push(8'h30 + 8'(i), SRC_IN1);
            cycle_end();
        end
        in0_valid = 1'b1; in0_data = 8'h40;
        in1_data = 8'h50;
        @(negedge clk);
        check("t4_contend_sel", sel, 0);
        push(8'h40, SRC_IN0);
        cycle_end();
        in0_data = 8'h41;
        @(negedge clk);
        check("t4_second_sel", sel, 1);
        push(8'h50, SRC_IN1);
        cycle_end();

`ifdef RR_ARB2_LOCK_EN
        // 3-beat packet from in0 holds the grant against a valid in1
        do_reset();
        in1_valid = 1'b1; in1_data = 8'h71; in1_last = 1'b1;
        in0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in0_data = 8'h61 + 8'(i);
            in0_last = (i == 2);
            @(negedge clk);
            check("t5_lock_sel", sel, 0);
            push(8'h61 + 8'(i), SRC_IN0);
            cycle_end();
        end
        in0_data = 8'h64; in0_last = 1'b0;
        @(negedge clk);
        check("t5_after_pkt_sel", sel, 1);
        push(8'h71, SRC_IN1);
        cycle_end();
`endif

        // Asynchronous reset while FULL
        do_reset();
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'hC3;
        @(negedge clk);
        check("t6_in0_ready", in0_ready, 1);
        push(8'hC3, SRC_IN0);
        cycle_end();
        in0_valid = 1'b0;
        check("t6_full", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", out_valid, 0);
        check("t6_async_data", out_data, 0);
        exp_q.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h5A;
        #1;
        check("t6_post_rst_ready", in1_ready, 1);
        push(8'h5A, SRC_IN1);
        cycle_end();
        in1_valid = 1'b0;
        check("t6_post_rst_valid", out_valid, 1);

        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

endmodule
